// File: rtl/flash_port_arbiter.sv
// flash_port_arbiter: shares one byte-level flash engine between two requesters.
// Optional forced release of a hung owner: define FLASH_ARB_TIMEOUT_EN.
module flash_port_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMER_W        = 16,
  parameter int TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic [7:0] a_data,
  input  logic       a_latch,
  input  logic       a_continue,
  input  logic       a_wren,
  input  logic       a_rden,
  output logic       a_grant,
  output logic       a_ready,
  input  logic       b_req,
  input  logic [7:0] b_data,
  input  logic       b_latch,
  input  logic       b_continue,
  input  logic       b_wren,
  input  logic       b_rden,
  output logic       b_grant,
  output logic       b_ready,
  output logic [7:0] fl_data,
  output logic       fl_latch,
  output logic       fl_continue,
  output logic       fl_wren,
  output logic       fl_rden,
  input  logic       fl_ready,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;

  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);

  state_t             state, state_nx;
  logic               last_b, last_b_nx;
  logic [TIMER_W-1:0] cnt, cnt_nx, cnt_inc;
  logic               tmo_hit;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYCLES);
  assign tmo_hit = (cnt == TMO_LAST);

  // Sticky flag: set when an owner is forcibly released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timeout_err <= 1'b0;
    else if (tmo_hit && (state == OWN_A || state == OWN_B))
      timeout_err <= 1'b1;
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State, fairness pointer and gap/timeout counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_b <= 1'b1;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      last_b <= last_b_nx;
      cnt    <= cnt_nx;
    end
  end

  // Next-state: whole-transaction grants, round-robin on ties, gap after release.
  always_comb begin
    state_nx  = state;
    last_b_nx = last_b;
    cnt_nx    = cnt;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (a_req && (!b_req || last_b))
          state_nx = OWN_A;
        else if (b_req)
          state_nx = OWN_B;
      end
      OWN_A: begin
`ifdef FLASH_ARB_TIMEOUT_EN
        cnt_nx = (a_latch && fl_ready) ? '0 : cnt_inc;
`endif
        if ((!a_req && !a_continue) || tmo_hit) begin
          state_nx  = GAP;
          last_b_nx = 1'b0;
          cnt_nx    = '0;
        end
      end
      OWN_B: begin
`ifdef FLASH_ARB_TIMEOUT_EN
        cnt_nx = (b_latch && fl_ready) ? '0 : cnt_inc;
`endif
        if ((!b_req && !b_continue) || tmo_hit) begin
          state_nx  = GAP;
          last_b_nx = 1'b1;
          cnt_nx    = '0;
        end
      end
      GAP: begin
        cnt_nx = cnt_inc;
        if (cnt == GAP_LAST)
          state_nx = IDLE;
      end
    endcase
  end

  // Output mux: only the current owner reaches the flash engine.
  always_comb begin
    a_grant     = 1'b0;
    b_grant     = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    fl_data     = 8'h00;
    fl_latch    = 1'b0;
    fl_continue = 1'b0;
    fl_wren     = 1'b0;
    fl_rden     = 1'b0;
    busy        = (state != IDLE);
    unique case (state)
      OWN_A: begin
        a_grant     = 1'b1;
        a_ready     = fl_ready;
        fl_data     = a_data;
        fl_latch    = a_latch;
        fl_continue = a_continue;
        fl_wren     = a_wren;
        fl_rden     = a_rden;
      end
      OWN_B: begin
        b_grant     = 1'b1;
        b_ready     = fl_ready;
        fl_data     = b_data;
        fl_latch    = b_latch;
        fl_continue = b_continue;
        fl_wren     = b_wren;
        fl_rden     = b_rden;
      end
      IDLE, GAP: begin
      end
    endcase
  end

endmodule
